// File: rtl/booth_seq_mult_ctrl.sv
// Sequential radix-2 Booth signed multiplier controller.
// Takes one operand pair over a valid/ready handshake, runs exactly WIDTH
// add/subtract-and-shift steps (one per clock), then holds the 2*WIDTH-bit
// product on a valid/ready output until the consumer takes it.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both high; the producer holds its data stable
// while valid is high and ready is low. in_ready is high only in IDLE and
// out_valid is high only in DONE. flush takes priority over both
// transfers in the same cycle.
module booth_seq_mult_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               flush,
  output logic               busy,
  output logic [CNT_W-1:0]   step,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t state, state_nxt;

  // A and M carry one extra sign bit so the most-negative multiplicand
  // can be negated without overflow.
  logic [WIDTH:0]       a_reg;
  logic [WIDTH:0]       m_reg;
  logic [WIDTH-1:0]     q_reg;
  logic                 q_m1;
  logic [CNT_W-1:0]     step_reg;
  logic [2*WIDTH-1:0]   z_reg;

  logic                 accept;
  logic                 last_step;
  logic [WIDTH:0]       a_sum;
  logic [WIDTH:0]       a_shift;
  logic [WIDTH-1:0]     q_shift;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and handshake outputs; flush forces IDLE and
  // suppresses acceptance and result capture.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (step_reg == LAST_STEP) begin
          last_step = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (flush) begin
      state_nxt = IDLE;
      accept    = 1'b0;
      last_step = 1'b0;
    end
  end

  // One Booth step: add/subtract M based on {Q[0], q_m1}, then arithmetic
  // shift right of {A, Q, q_m1} with the A sign bit replicated.
  always_comb begin
    a_sum = a_reg;
    case ({q_reg[0], q_m1})
      2'b10:   a_sum = a_reg - m_reg;
      2'b01:   a_sum = a_reg + m_reg;
      default: a_sum = a_reg;
    endcase
    a_shift = {a_sum[WIDTH], a_sum[WIDTH:1]};
    q_shift = {a_sum[0], q_reg[WIDTH-1:1]};
  end

  // Datapath: load on accept, iterate in RUN, capture product on last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      m_reg    <= '0;
      q_reg    <= '0;
      q_m1     <= 1'b0;
      step_reg <= '0;
      z_reg    <= '0;
    end else if (flush) begin
      step_reg <= '0;
    end else if (accept) begin
      a_reg    <= '0;
      m_reg    <= {y[WIDTH-1], y};
      q_reg    <= x;
      q_m1     <= 1'b0;
      step_reg <= '0;
    end else if (state == RUN) begin
      a_reg <= a_shift;
      q_reg <= q_shift;
      q_m1  <= q_reg[0];
      if (last_step) begin
        step_reg <= '0;
        z_reg    <= {a_shift[WIDTH-1:0], q_shift};
      end else begin
        step_reg <= step_reg + 1'b1;
      end
    end
  end

  assign step = step_reg;
  assign z    = z_reg;

endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// Self-checking bench for booth_seq_mult_ctrl (WIDTH=4). Accepted operand
// pairs push a reference product into exp_q; each output handshake pops
// and compares. Directed tests cover latency, signed corners, an
// exhaustive sweep, backpressure, flush and asynchronous reset.
module tb_booth_seq_mult_ctrl;

  localparam int W  = 4;
  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic          flush;
  logic          busy;
  logic [CW-1:0] step;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] z;

  logic [2*W-1:0] exp_q[$];
  int n_cmp;
  int n_err;

  booth_seq_mult_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .flush     (flush),
    .busy      (busy),
    .step      (step),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  // Scoreboard: push on accept, pop on output handshake, drop on abort.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else if (flush) begin
      if (busy || out_valid) exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("z_unexpected", 32'd1, 32'd0);
        else chk("z_sb", {24'd0, z}, {24'd0, exp_q.pop_front()});
      end
      if (in_valid && in_ready) exp_q.push_back(ref_mul(x, y));
    end
  end

  // Driver: one full transaction from IDLE with out_ready high, checking
  // busy/step/handshake timing every cycle.
  task automatic do_op(input logic [W-1:0] xv, input logic [W-1:0] yv);
    @(posedge clk); #1;
    x = xv; y = yv; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < W; c++) begin
      chk("run_busy", {31'd0, busy}, 32'd1);
      chk("run_step", {29'd0, step}, c);
      chk("run_in_ready", {31'd0, in_ready}, 32'd0);
      chk("run_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    chk("done_out_valid", {31'd0, out_valid}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  logic [W-1:0]   cx [5] = '{4'h8, 4'h8, 4'h7, 4'hF, 4'h0};
  logic [W-1:0]   cy [5] = '{4'h8, 4'h7, 4'h8, 4'hF, 4'hB};
  logic [2*W-1:0] cz [5] = '{8'h40, 8'hC8, 8'hC8, 8'h01, 8'h00};
  logic [2*W-1:0] z_prev;

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; flush = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_step", {29'd0, step}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_z", {24'd0, z}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Basic 3*5
    do_op(4'h3, 4'h5);
    chk("z_3x5", {24'd0, z}, 32'h0F);

    // Signed corners
    for (int i = 0; i < 5; i++) begin
      do_op(cx[i], cy[i]);
      chk("z_corner", {24'd0, z}, {24'd0, cz[i]});
    end

    // Exhaustive sweep
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        do_op(i[W-1:0], j[W-1:0]);

    // Backpressure: -3 * 6 held for 10 cycles
    @(posedge clk); #1;
    out_ready = 1'b0; x = 4'hD; y = 4'h6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (W) @(posedge clk);
    #1;
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_z", {24'd0, z}, 32'hEE);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; x = 4'h1; y = 4'h1;
      @(posedge clk); #1;
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_z", {24'd0, z}, 32'hEE);
      chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_z", {24'd0, z}, 32'hEE);

    // Operands change during RUN
    @(posedge clk); #1;
    x = 4'h2; y = 4'h2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; x = 4'h7; y = 4'h7;
    repeat (W) @(posedge clk);
    #1;
    chk("chg_out_valid", {31'd0, out_valid}, 32'd1);
    chk("chg_z", {24'd0, z}, 32'h04);
    @(posedge clk); #1;

    // Flush at step 2
    z_prev = z;
    @(posedge clk); #1;
    x = 4'h4; y = 4'h3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("fl_step", {29'd0, step}, 32'd2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    chk("fl_busy", {31'd0, busy}, 32'd0);
    chk("fl_step0", {29'd0, step}, 32'd0);
    chk("fl_z", {24'd0, z}, {24'd0, z_prev});
    for (int i = 0; i < W + 2; i++) begin
      chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    do_op(4'h5, 4'hE);
    chk("z_5xm2", {24'd0, z}, 32'hF6);

    // Asynchronous reset between edges during RUN
    @(posedge clk); #1;
    x = 4'h3; y = 4'h3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_step", {29'd0, step}, 32'd0);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_z", {24'd0, z}, 32'd0);
    #10 rst = 1'b0;
    do_op(4'hE, 4'h3);
    chk("z_m2x3", {24'd0, z}, 32'hFA);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
